lcd_bus_driver: RTL and testbench
=================================

Name: lcd_bus_driver

Overview:
- Memory-mapped peripheral behind the CPU data port, sitting between the CPU store path and the external HD44780-style character LCD pins.
- Accepts command/data bytes from CPU writes into a FIFO.
- Sequences each byte onto the LCD bus with programmed setup, enable-pulse, hold and execution-wait timing, so firmware no longer bit-bangs data/ctrl/enable registers.
- Exposes busy, fill-level and overflow status for polling.

Parameters:
- FIFO_DEPTH, 16, entries in the byte FIFO (power of two, >= 2).
- T_SETUP, 2, cycles RS/data stable before E rises (>= 1).
- T_PULSE, 12, cycles E held high (>= 1).
- T_HOLD, 2, cycles RS/data held after E falls (>= 1).
- T_EXEC, 2000, post-transfer wait for ordinary commands/data (>= 1).
- T_CLEAR, 82000, post-transfer wait for clear (0x01) / home (0x02) commands (>= 1).
- CNT_W, 17, phase counter width; must hold max(T_*) - 1.

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous active-high reset
- wr_en  in  1  CPU write strobe, one byte per cycle
- wr_data  in  8  byte to send
- wr_rs  in  1  register select for this byte: 0 = command, 1 = character data
- clr_overflow  in  1  clears the sticky overflow flag
- full  out  1  FIFO full
- busy  out  1  FIFO non-empty or FSM not IDLE
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a write was dropped
- lcd_data  out  8  LCD data bus
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write, tied 0 (write-only)
- lcd_e  out  1  LCD enable strobe

Behaviour:
- Reset (rst sampled high at posedge):
  - FSM goes to IDLE; FIFO is emptied.
  - Outputs: lcd_data=0, lcd_rs=0, lcd_e=0, overflow=0, fifo_count=0, full=0, busy=0.
  - Applies mid-transfer too: lcd_e drops on that edge and no partial phase resumes.
- FIFO: entries are {rs, data}, 9 bits, strict first-in first-out.
- Write acceptance: a write is accepted when wr_en=1 and either the FIFO is not full, or it is full and a pop happens on the same edge.
- Dropped write: otherwise the write is dropped, overflow is set, and FIFO contents are unchanged.
- clr_overflow clears overflow. If clr_overflow and a dropped write occur in the same cycle, overflow ends set.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT. Each timed phase loads its counter with T-1 on entry, counts down, and exits on the edge where the counter is 0, so each phase lasts exactly T cycles.
- IDLE: if FIFO non-empty, pop the head on this edge; lcd_data/lcd_rs take the popped values; go to SETUP. If empty, stay. A byte written to an empty FIFO at edge n is popped at edge n+1 (no bypass).
- SETUP: lcd_e=0 for T_SETUP cycles, then go to PULSE (lcd_e=1 from that edge).
- PULSE: lcd_e=1 for T_PULSE cycles, then go to HOLD (lcd_e=0 from that edge).
- HOLD: lcd_e=0 and lcd_data/lcd_rs unchanged for T_HOLD cycles, then go to WAIT.
- WAIT:
  - Wait length is T_CLEAR if the transferred byte had rs=0 and data in {0x01, 0x02}; otherwise T_EXEC.
  - Then go to IDLE.
  - lcd_data/lcd_rs keep their last values until the next pop.
- Each byte spends one cycle in IDLE between transfers, so back-to-back bytes are T_SETUP+T_PULSE+T_HOLD+T_WAIT+1 cycles apart.
- lcd_e is registered and glitch-free; it changes only on state-entry edges into PULSE and HOLD (or on reset).
- busy = (state != IDLE) || (fifo_count != 0), registered-equivalent, no combinational path from wr_en.
- full = (fifo_count == FIFO_DEPTH).
- Counter arithmetic is unsigned CNT_W bits and never wraps, because every load is T-1.

Test Plan:
(Parameters: FIFO_DEPTH=4, T_SETUP=2, T_PULSE=4, T_HOLD=2, T_EXEC=10, T_CLEAR=50. Edge 0 = edge where the first write is sampled.)
- Single data byte wr_data=0x41, wr_rs=1 at edge 0 -> lcd_data=0x41, lcd_rs=1 from edge 1; lcd_e=1 from edge 3 to edge 7; WAIT from edge 9; IDLE and busy=0 at edge 19; lcd_rw always 0.
- Clear command 0x01, rs=0 at edge 0 -> same strobe timing; IDLE at edge 59. Repeat with 0x01 sent as rs=1 -> IDLE at edge 19 (T_EXEC).
- Six writes on consecutive edges 0..5 (0x10..0x15) -> 0x10 popped at edge 1; 0x11..0x14 fill FIFO (full=1, fifo_count=4 after edge 4); 0x15 dropped with overflow=1. Bytes then appear on lcd_data in order 0x10..0x14, one pop every 19 cycles (edges 1, 20, 39, ...).
- Write on the exact edge the FSM pops from a full FIFO -> accepted, fifo_count stays 4, overflow stays 0.
- rst asserted for 1 cycle while lcd_e=1 with 2 bytes queued -> on that edge lcd_e=0, fifo_count=0, busy=0, overflow=0, lcd_data=0. A new write afterwards follows single-byte timing exactly.
- overflow set, then clr_overflow pulsed -> overflow=0 next edge. clr_overflow coincident with a dropped write -> overflow remains 1.

Source files
------------

// File: rtl/lcd_bus_if.sv
// CPU-side write port, status and LCD pin bundle for the LCD bus driver.
interface lcd_bus_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          wr_rs;
    logic          clr_overflow;
    logic          full;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic [7:0]    lcd_data;
    logic          lcd_rs;
    logic          lcd_rw;
    logic          lcd_e;

    modport master (
        output wr_en, wr_data, wr_rs, clr_overflow,
        input  full, busy, fifo_count, overflow,
        input  lcd_data, lcd_rs, lcd_rw, lcd_e
    );

    modport slave (
        input  wr_en, wr_data, wr_rs, clr_overflow,
        output full, busy, fifo_count, overflow,
        output lcd_data, lcd_rs, lcd_rw, lcd_e
    );
endinterface

// File: rtl/lcd_bus_driver.sv
// HD44780-style LCD bus sequencer: CPU bytes queue in a FIFO and are strobed
// onto the LCD pins with setup / enable / hold / execution-wait timing.
//
// state | meaning
// IDLE  | waiting for a queued byte; pops head when FIFO non-empty
// SETUP | rs/data driven, E low, T_SETUP cycles
// PULSE | E high, T_PULSE cycles
// HOLD  | E low, rs/data held, T_HOLD cycles
// WAIT  | LCD executing, T_EXEC or T_CLEAR (clear/home) cycles
module lcd_bus_driver #(
    parameter int FIFO_DEPTH = 16,
    parameter int T_SETUP    = 2,
    parameter int T_PULSE    = 12,
    parameter int T_HOLD     = 2,
    parameter int T_EXEC     = 2000,
    parameter int T_CLEAR    = 82000,
    parameter int CNT_W      = 17
) (
    input  logic        clk,
    input  logic        rst,
    lcd_bus_if.slave    bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(T_CLEAR - 1);

    logic [8:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       data_q;
    logic             rs_q;
    logic             e_q;
    logic             ovf_q;

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push;
    logic drop;
    logic long_cmd;

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    // A pop frees a slot on the same edge, so a full FIFO can still take a write then.
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign push       = bus.wr_en && (!fifo_full || pop);
    assign drop       = bus.wr_en && !push;
    // Clear display and return home need the long execution wait.
    assign long_cmd   = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.wr_rs, bus.wr_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Sticky overflow; a drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (bus.clr_overflow) begin
            ovf_q <= 1'b0;
        end
    end

    // Transfer sequencer: each timed phase loads T-1 and leaves when the count hits 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            data_q <= 8'h00;
            rs_q   <= 1'b0;
            e_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        {rs_q, data_q} <= mem[rd_ptr];
                        cnt            <= LD_SETUP;
                        state          <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        e_q   <= 1'b1;
                        cnt   <= LD_PULSE;
                        state <= S_PULSE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt == '0) begin
                        e_q   <= 1'b0;
                        cnt   <= LD_HOLD;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= long_cmd ? LD_CLEAR : LD_EXEC;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    e_q   <= 1'b0;
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.full       = fifo_full;
    assign bus.busy       = (state != S_IDLE) || !fifo_empty;
    assign bus.fifo_count = count;
    assign bus.overflow   = ovf_q;
    assign bus.lcd_data   = data_q;
    assign bus.lcd_rs     = rs_q;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_e      = e_q;
endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver with short timing parameters.
module tb_lcd_bus_driver;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    lcd_bus_if #(.FIFO_DEPTH(4)) bus ();

    lcd_bus_driver #(
        .FIFO_DEPTH(4),
        .T_SETUP   (2),
        .T_PULSE   (4),
        .T_HOLD    (2),
        .T_EXEC    (10),
        .T_CLEAR   (50),
        .CNT_W     (17)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en        = 1'b0;
        bus.wr_data      = 8'h00;
        bus.wr_rs        = 1'b0;
        bus.clr_overflow = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        total += 8;
        if (bus.lcd_data !== 8'h00) begin bad++; $display("FAIL reset_data got %h want 00", bus.lcd_data); end
        if (bus.lcd_rs !== 1'b0) begin bad++; $display("FAIL reset_rs got %b want 0", bus.lcd_rs); end
        if (bus.lcd_e !== 1'b0) begin bad++; $display("FAIL reset_e got %b want 0", bus.lcd_e); end
        if (bus.lcd_rw !== 1'b0) begin bad++; $display("FAIL reset_rw got %b want 0", bus.lcd_rw); end
        if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
        if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got %0d want 0", bus.fifo_count); end
        if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got %b want 0", bus.full); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        rst = 1'b0;
        step();
    endtask

    // One byte from an idle, empty driver; idle_edge is when busy must fall.
    task automatic test_single(input logic [7:0] d, input logic r, input int idle_edge, input string nm);
        logic exp_e;
        logic exp_busy;
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        bus.wr_rs   = r;
        step();
        idle_inputs();
        total += 2;
        if (bus.fifo_count !== 3'd1) begin bad++; $display("FAIL %s_count0 got %0d want 1", nm, bus.fifo_count); end
        if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s_busy0 got %b want 1", nm, bus.busy); end
        for (int k = 1; k <= idle_edge + 1; k++) begin
            step();
            exp_e    = (k >= 3) && (k < 7);
            exp_busy = (k < idle_edge);
            total += 5;
            if (bus.lcd_e !== exp_e) begin bad++; $display("FAIL %s_e edge %0d got %b want %b", nm, k, bus.lcd_e, exp_e); end
            if (bus.busy !== exp_busy) begin bad++; $display("FAIL %s_busy edge %0d got %b want %b", nm, k, bus.busy, exp_busy); end
            if (bus.lcd_data !== d) begin bad++; $display("FAIL %s_data edge %0d got %h want %h", nm, k, bus.lcd_data, d); end
            if (bus.lcd_rs !== r) begin bad++; $display("FAIL %s_rs edge %0d got %b want %b", nm, k, bus.lcd_rs, r); end
            if (bus.lcd_rw !== 1'b0) begin bad++; $display("FAIL %s_rw edge %0d got %b want 0", nm, k, bus.lcd_rw); end
        end
    endtask

    // Burst of six writes, overflow clear, and a write landing on a full-FIFO pop.
    task automatic test_back_to_back();
        logic [2:0] exp_cnt [6];
        logic [7:0] exp_byte;
        exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        for (int k = 0; k <= 115; k++) begin
            idle_inputs();
            if (k <= 5) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = 8'h10 + 8'(k);
                bus.wr_rs   = 1'b1;
            end else if (k == 6) begin
                bus.clr_overflow = 1'b1;
            end else if (k == 20) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = 8'h16;
                bus.wr_rs   = 1'b1;
            end
            step();
            if (k <= 5) begin
                total += 3;
                if (bus.fifo_count !== exp_cnt[k]) begin bad++; $display("FAIL b2b_count edge %0d got %0d want %0d", k, bus.fifo_count, exp_cnt[k]); end
                if (bus.full !== (k >= 4)) begin bad++; $display("FAIL b2b_full edge %0d got %b want %b", k, bus.full, (k >= 4)); end
                if (bus.overflow !== (k == 5)) begin bad++; $display("FAIL b2b_ovf edge %0d got %b want %b", k, bus.overflow, (k == 5)); end
            end
            if (k == 6) begin
                total++;
                if (bus.overflow !== 1'b0) begin bad++; $display("FAIL b2b_clr got %b want 0", bus.overflow); end
            end
            if (k == 20) begin
                total += 3;
                if (bus.fifo_count !== 3'd4) begin bad++; $display("FAIL b2b_popwr_count got %0d want 4", bus.fifo_count); end
                if (bus.full !== 1'b1) begin bad++; $display("FAIL b2b_popwr_full got %b want 1", bus.full); end
                if (bus.overflow !== 1'b0) begin bad++; $display("FAIL b2b_popwr_ovf got %b want 0", bus.overflow); end
            end
            if ((k >= 20) && ((k - 1) % 19 == 0) && (k <= 96)) begin
                exp_byte = (k == 96) ? 8'h16 : 8'h10 + 8'((k - 1) / 19);
                total += 2;
                if (bus.lcd_data !== exp_byte) begin bad++; $display("FAIL b2b_order edge %0d got %h want %h", k, bus.lcd_data, exp_byte); end
                if (bus.fifo_count !== 3'(5 - (k - 1) / 19)) begin bad++; $display("FAIL b2b_drain edge %0d got %0d want %0d", k, bus.fifo_count, 5 - (k - 1) / 19); end
            end
            if (k == 1) begin
                total++;
                if (bus.lcd_data !== 8'h10) begin bad++; $display("FAIL b2b_first got %h want 10", bus.lcd_data); end
            end
            if (k == 113 || k == 114) begin
                total++;
                if (bus.busy !== (k == 113)) begin bad++; $display("FAIL b2b_busy edge %0d got %b want %b", k, bus.busy, (k == 113)); end
            end
        end
        idle_inputs();
    endtask

    // Overflow set, clear coincident with a drop, plain clear, set again.
    task automatic test_overflow();
        for (int k = 0; k <= 8; k++) begin
            idle_inputs();
            if (k != 7) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = 8'h20 + 8'(k);
                bus.wr_rs   = 1'b1;
            end
            if (k == 6 || k == 7) bus.clr_overflow = 1'b1;
            step();
            if (k == 4) begin
                total += 2;
                if (bus.fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count got %0d want 4", bus.fifo_count); end
                if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_pre got %b want 0", bus.overflow); end
            end
            if (k == 5 || k == 6 || k == 8) begin
                total++;
                if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set edge %0d got %b want 1", k, bus.overflow); end
            end
            if (k == 7) begin
                total++;
                if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got %b want 0", bus.overflow); end
            end
        end
        idle_inputs();
        total++;
        if (bus.fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_keep got %0d want 4", bus.fifo_count); end
    endtask

    // Reset while E is high with two bytes queued.
    task automatic test_reset_mid();
        for (int k = 0; k <= 4; k++) begin
            idle_inputs();
            if (k <= 2) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = 8'hA0 + 8'(k);
                bus.wr_rs   = 1'b1;
            end
            step();
            if (k == 2) begin
                total++;
                if (bus.fifo_count !== 3'd2) begin bad++; $display("FAIL rmid_count got %0d want 2", bus.fifo_count); end
            end
            if (k == 4) begin
                total++;
                if (bus.lcd_e !== 1'b1) begin bad++; $display("FAIL rmid_e_pre got %b want 1", bus.lcd_e); end
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total += 5;
        if (bus.lcd_e !== 1'b0) begin bad++; $display("FAIL rmid_e got %b want 0", bus.lcd_e); end
        if (bus.fifo_count !== 3'd0) begin bad++; $display("FAIL rmid_count0 got %0d want 0", bus.fifo_count); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
        if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rmid_ovf got %b want 0", bus.overflow); end
        if (bus.lcd_data !== 8'h00) begin bad++; $display("FAIL rmid_data got %h want 00", bus.lcd_data); end
        step();
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_noresume got %b want 0", bus.busy); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        test_reset();
        test_single(8'h41, 1'b1, 19, "data41");
        test_single(8'h01, 1'b0, 59, "clear");
        test_single(8'h01, 1'b1, 19, "char01");
        test_single(8'h02, 1'b0, 59, "home");
        test_single(8'h03, 1'b0, 19, "cmd03");
        test_back_to_back();
        test_overflow();
        test_reset();
        test_reset_mid();
        test_single(8'h55, 1'b1, 19, "after_rst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
